// File: rtl/csync_sequencer.sv
// Composite sync / blank / colour-burst sequencer for VIC-II style raster timing.
// Produces registered sync, blanking, vertical-serration line state and the burst gate
// from the raster position, using per-chip timing latched once per frame.
module csync_sequencer #(
    parameter int unsigned NTSC_BURST_LEN = 82,
    parameter int unsigned PAL_BURST_LEN  = 64
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic [9:0] raster_x,
    input  logic [8:0] raster_y,
    input  logic [1:0] chip,
    output logic       sync_n,
    output logic       blank,
    output logic [2:0] line_state,
    output logic       burst_gate,
    output logic       burst_odd
);

    localparam logic [7:0] NtscLen = 8'(NTSC_BURST_LEN);
    localparam logic [7:0] PalLen  = 8'(PAL_BURST_LEN);

    typedef enum logic [2:0] {
        StActive = 3'd0,
        StEq1    = 3'd1,
        StSerr   = 3'd2,
        StEq2    = 3'd3
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] chip_q, chip_d;
    logic [9:0] prev_x_q;
    logic [8:0] prev_y_q;
    logic [1:0] line_cnt_q, line_cnt_d;
    logic       armed_q, armed_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       sync_n_q, sync_n_d;
    logic       blank_q, blank_d;
    logic       burst_gate_q, burst_gate_d;
    logic       burst_odd_q, burst_odd_d;

    logic       frame_start;
    logic       line_start;
    logic [9:0] y10;
    logic [9:0] hsync_start, hsync_end, hvis_start;
    logic [9:0] vvis_end, vblank_start, vvis_start, line_len, hl;
    logic [9:0] burst_x;
    logic [7:0] burst_len;
    logic       armed_pre, burst_start, burst_abort;

    assign y10         = {1'b0, raster_y};
    assign line_start  = (raster_y != prev_y_q);
    // Only the first cycle of x==0,y==0 counts; x holds for several cycles.
    assign frame_start = (raster_x == 10'd0) && (raster_y == 9'd0) &&
                         !((prev_x_q == 10'd0) && (prev_y_q == 9'd0));
    assign chip_d      = frame_start ? chip : chip_q;
    assign hl          = {1'b0, line_len[9:1]};

    // Per-chip timing constants, taken from the chip value in force this cycle.
    always_comb begin
        if (chip_d[0]) begin
            hsync_start  = 10'd7;
            hsync_end    = 10'd44;
            hvis_start   = 10'd91;
            vvis_end     = 10'd300;
            vblank_start = 10'd301;
            vvis_start   = 10'd310;
            line_len     = 10'd504;
            burst_x      = 10'd49;
            burst_len    = PalLen;
        end else begin
            hsync_start  = 10'd8;
            hsync_end    = 10'd45;
            hvis_start   = 10'd96;
            vvis_end     = 10'd13;
            vblank_start = 10'd14;
            vvis_start   = 10'd23;
            line_len     = chip_d[1] ? 10'd512 : 10'd520;
            burst_x      = 10'd50;
            burst_len    = NtscLen;
        end
    end

    // Vertical sync sequence: three lines each of EQ1, SERR, EQ2, advanced on line starts.
    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        if (line_start) begin
            unique case (state_q)
                StActive: begin
                    if (y10 == vblank_start) begin
                        state_d    = StEq1;
                        line_cnt_d = 2'd0;
                    end
                end
                StEq1, StSerr, StEq2: begin
                    if (line_cnt_q == 2'd2) begin
                        line_cnt_d = 2'd0;
                        state_d    = (state_q == StEq1) ? StSerr :
                                     (state_q == StSerr) ? StEq2 : StActive;
                    end else begin
                        line_cnt_d = line_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_d    = StActive;
                    line_cnt_d = 2'd0;
                end
            endcase
        end
    end

    // Sync and blank decode against the state that this cycle's raster position selects.
    always_comb begin
        sync_n_d = 1'b1;
        unique case (state_d)
            StEq1, StEq2: sync_n_d = !((raster_x < 10'd19) ||
                                       ((raster_x >= hl) && (raster_x < hl + 10'd19)));
            StSerr:       sync_n_d = !((raster_x < hl - 10'd37) ||
                                       ((raster_x >= hl) && (raster_x < line_len - 10'd37)));
            default:      sync_n_d = !((raster_x >= hsync_start) && (raster_x < hsync_end));
        endcase
        blank_d = (state_d != StActive) || (raster_x < hvis_start) ||
                  ((y10 >= vvis_end) && (y10 < vvis_start)) ||
                  ((y10 == vvis_start) && (raster_x <= hvis_start));
    end

    // Burst gate: one start per line, aborted by a new line or by leaving ACTIVE.
    always_comb begin
        armed_pre   = line_start || armed_q;
        burst_abort = line_start || ((state_q == StActive) && (state_d != StActive));
        burst_start = armed_pre && (raster_x == burst_x) && (raster_x != prev_x_q) &&
                      (state_d == StActive) && blank_d;
        armed_d     = armed_pre && !burst_start;
        if (burst_start) begin
            burst_cnt_d = burst_len;
        end else if (burst_abort) begin
            burst_cnt_d = 8'd0;
        end else if (burst_cnt_q != 8'd0) begin
            burst_cnt_d = burst_cnt_q - 8'd1;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
        burst_gate_d = (burst_cnt_d != 8'd0);
        burst_odd_d  = burst_start ? raster_y[0] : burst_odd_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            state_q      <= StActive;
            chip_q       <= chip;
            prev_x_q     <= raster_x;
            prev_y_q     <= raster_y;
            line_cnt_q   <= 2'd0;
            armed_q      <= 1'b0;
            burst_cnt_q  <= 8'd0;
            sync_n_q     <= 1'b1;
            blank_q      <= 1'b1;
            burst_gate_q <= 1'b0;
            burst_odd_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            chip_q       <= chip_d;
            prev_x_q     <= raster_x;
            prev_y_q     <= raster_y;
            line_cnt_q   <= line_cnt_d;
            armed_q      <= armed_d;
            burst_cnt_q  <= burst_cnt_d;
            sync_n_q     <= sync_n_d;
            blank_q      <= blank_d;
            burst_gate_q <= burst_gate_d;
            burst_odd_q  <= burst_odd_d;
        end
    end

    assign sync_n     = sync_n_q;
    assign blank      = blank_q;
    assign line_state = state_q;
    assign burst_gate = burst_gate_q;
    assign burst_odd  = burst_odd_q;

endmodule

// File: tb/tb_csync_sequencer.sv
// Self-checking bench for csync_sequencer: constant vector table, directed frame
// sequences and randomized raster traffic compared against a line-counting model.
module tb_csync_sequencer;

    localparam int NtscLen = 82;
    localparam int PalLen  = 64;

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raster_x = '0;
    logic [8:0] raster_y = '0;
    logic [1:0] chip = '0;
    logic       sync_n, blank, burst_gate, burst_odd;
    logic [2:0] line_state;

    csync_sequencer #(
        .NTSC_BURST_LEN(NtscLen),
        .PAL_BURST_LEN (PalLen)
    ) dut (
        .clk_dot4x (clk_dot4x),
        .rst       (rst),
        .raster_x  (raster_x),
        .raster_y  (raster_y),
        .chip      (chip),
        .sync_n    (sync_n),
        .blank     (blank),
        .line_state(line_state),
        .burst_gate(burst_gate),
        .burst_odd (burst_odd)
    );

    initial forever #5 clk_dot4x = ~clk_dot4x;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model state: vb_line counts lines since the vertical sequence began (-1 = ACTIVE).
    int m_chip, m_prev_x, m_prev_y, m_vb, m_bstart;
    bit m_armed, m_odd;
    int e_sync, e_blank, e_state, e_gate, e_odd;

    // Per-line observations of the DUT.
    int lo_cnt, lo_min_x, lo_max_x, gate_cnt, gate_first, x49_cyc;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic get_consts(input int c, output int hs, output int he, output int hv,
                              output int ve, output int vb, output int vs, output int ll);
        if (c % 2 == 1) begin
            hs = 7; he = 44; hv = 91; ve = 300; vb = 301; vs = 310; ll = 504;
        end else begin
            hs = 8; he = 45; hv = 96; ve = 13; vb = 14; vs = 23; ll = (c == 0) ? 520 : 512;
        end
    endtask

    task automatic model(input bit r, input int c, input int x, input int y);
        int hs, he, hv, ve, vb, vs, ll, hl, st, bx, blen;
        bit ls, start;
        if (r) begin
            m_chip = c; m_prev_x = x; m_prev_y = y; m_vb = -1;
            m_armed = 0; m_bstart = -1; m_odd = 0;
            e_sync = 1; e_blank = 1; e_state = 0; e_gate = 0; e_odd = 0;
        end else begin
            if (x == 0 && y == 0 && !(m_prev_x == 0 && m_prev_y == 0)) m_chip = c;
            get_consts(m_chip, hs, he, hv, ve, vb, vs, ll);
            hl = ll / 2;
            bx = (m_chip % 2 == 1) ? 49 : 50;
            blen = (m_chip % 2 == 1) ? PalLen : NtscLen;
            ls = (y != m_prev_y);
            if (ls) begin
                if (m_vb < 0) begin
                    if (y == vb) m_vb = 0;
                end else begin
                    m_vb++;
                    if (m_vb == 9) m_vb = -1;
                end
            end
            st = (m_vb < 0) ? 0 : 1 + m_vb / 3;
            if (st == 0) e_sync = (x >= hs && x < he) ? 0 : 1;
            else if (st == 2) e_sync = (x < hl - 37 || (x >= hl && x < ll - 37)) ? 0 : 1;
            else e_sync = (x < 19 || (x >= hl && x < hl + 19)) ? 0 : 1;
            e_blank = (st != 0 || x < hv || (y >= ve && y < vs) || (y == vs && x <= hv)) ? 1 : 0;
            e_state = st;
            if (ls) begin
                m_bstart = -1;
                m_armed  = 1;
            end
            start = m_armed && x == bx && x != m_prev_x && st == 0 && e_blank == 1;
            if (start) begin
                m_bstart = cyc;
                m_armed  = 0;
                m_odd    = y[0];
            end
            e_gate = (m_bstart >= 0 && cyc - m_bstart < blen) ? 1 : 0;
            e_odd  = m_odd;
            m_prev_x = x;
            m_prev_y = y;
        end
    endtask

    task automatic step(input bit r, input int c, input int x, input int y);
        rst = r;
        chip = 2'(c);
        raster_x = 10'(x);
        raster_y = 9'(y);
        model(r, c, x, y);
        @(posedge clk_dot4x);
        #1;
        check("sync_n", sync_n, e_sync);
        check("blank", blank, e_blank);
        check("line_state", line_state, e_state);
        check("burst_gate", burst_gate, e_gate);
        check("burst_odd", burst_odd, e_odd);
        if (!sync_n) begin
            lo_cnt++;
            if (x < lo_min_x) lo_min_x = x;
            if (x > lo_max_x) lo_max_x = x;
        end
        if (burst_gate) begin
            if (gate_cnt == 0) gate_first = cyc;
            gate_cnt++;
        end
        cyc++;
    endtask

    task automatic clr_trk();
        lo_cnt = 0; lo_min_x = 1023; lo_max_x = -1; gate_cnt = 0; gate_first = -1;
        x49_cyc = -1;
    endtask

    task automatic run_line(input int c, input int y, input int xmax, input int hold);
        clr_trk();
        for (int x = 0; x <= xmax; x++) begin
            for (int h = 0; h < hold; h++) begin
                if (x == 49 && h == 0) x49_cyc = cyc;
                step(0, c, x, y);
            end
        end
    endtask

    typedef struct {
        int chip;
        int x;
        int y;
        int s;
        int b;
    } vec_t;

    vec_t tbl[22];

    initial begin
        int exp_st, exp_lo, exp_max, c, y, vbs, nl, xmax, hold, r;

        tbl[0]  = '{0, 7, 50, 1, 1};    tbl[1]  = '{0, 8, 50, 0, 1};
        tbl[2]  = '{0, 44, 50, 0, 1};   tbl[3]  = '{0, 45, 50, 1, 1};
        tbl[4]  = '{0, 95, 50, 1, 1};   tbl[5]  = '{0, 96, 50, 1, 0};
        tbl[6]  = '{0, 300, 12, 1, 0};  tbl[7]  = '{0, 300, 13, 1, 1};
        tbl[8]  = '{0, 96, 23, 1, 1};   tbl[9]  = '{0, 97, 23, 1, 0};
        tbl[10] = '{1, 6, 100, 1, 1};   tbl[11] = '{1, 7, 100, 0, 1};
        tbl[12] = '{1, 43, 100, 0, 1};  tbl[13] = '{1, 44, 100, 1, 1};
        tbl[14] = '{1, 91, 100, 1, 0};  tbl[15] = '{1, 200, 299, 1, 0};
        tbl[16] = '{1, 200, 300, 1, 1}; tbl[17] = '{1, 500, 309, 1, 1};
        tbl[18] = '{1, 91, 310, 1, 1};  tbl[19] = '{1, 92, 310, 1, 0};
        tbl[20] = '{3, 7, 100, 0, 1};   tbl[21] = '{2, 44, 50, 0, 1};

        clr_trk();
        for (int i = 0; i < 22; i++) begin
            step(1, tbl[i].chip, tbl[i].x, tbl[i].y);
            check("rst_sync", sync_n, 1);
            check("rst_blank", blank, 1);
            check("rst_gate", burst_gate, 0);
            step(0, tbl[i].chip, tbl[i].x, tbl[i].y);
            check($sformatf("vec%0d_sync", i), sync_n, tbl[i].s);
            check($sformatf("vec%0d_blank", i), blank, tbl[i].b);
        end

        // NTSC R8 frame: vertical sequence from y=14.
        step(1, 0, 0, 0);
        for (int yy = 0; yy < 263; yy++) begin
            run_line(0, yy, (yy >= 12 && yy <= 24) ? 519 : 2, 1);
            if (yy >= 12 && yy <= 24) begin
                exp_st  = (yy < 14) ? 0 : (yy < 17) ? 1 : (yy < 20) ? 2 : (yy < 23) ? 3 : 0;
                exp_lo  = (exp_st == 0) ? 37 : (exp_st == 2) ? 446 : 38;
                exp_max = (exp_st == 0) ? 44 : (exp_st == 2) ? 482 : 278;
                check("a_state", line_state, exp_st);
                check("a_lo_cnt", lo_cnt, exp_lo);
                check("a_lo_max", lo_max_x, exp_max);
            end
        end

        // PAL active line with x held 4 cycles per value.
        step(1, 1, 0, 100);
        run_line(1, 101, 150, 4);
        check("b_gate_len", gate_cnt, 64);
        check("b_gate_delay", gate_first - x49_cyc, 0);
        check("b_odd", burst_odd, 1);
        check("b_lo_min", lo_min_x, 7);
        check("b_lo_max", lo_max_x, 43);
        run_line(1, 102, 150, 1);
        check("b_gate_len2", gate_cnt, 64);
        check("b_odd2", burst_odd, 0);

        // NTSC R56A: half line at 256.
        step(1, 2, 0, 12);
        for (int yy = 12; yy <= 24; yy++) begin
            run_line(2, yy, 511, 1);
            if (yy == 14) begin
                check("c_eq_lo_max", lo_max_x, 274);
                check("c_eq_lo_cnt", lo_cnt, 38);
            end
            if (yy == 17) check("c_serr_lo_max", lo_max_x, 474);
        end

        // Chip switches mid-frame; new timing only from the next frame.
        step(1, 0, 0, 95);
        for (int yy = 96; yy < 263; yy++) begin
            run_line((yy >= 100) ? 1 : 0, yy, (yy == 150) ? 60 : 2, 1);
            if (yy == 150) check("d_ntsc_min", lo_min_x, 8);
        end
        for (int yy = 0; yy <= 320; yy++) begin
            run_line(1, yy, (yy >= 299 && yy <= 312) ? 503 : ((yy == 0) ? 60 : 2), 1);
            if (yy == 0) check("d_pal_min", lo_min_x, 7);
            if (yy == 300) check("d_pal_active", line_state, 0);
            if (yy == 301) check("d_pal_eq1", line_state, 1);
        end

        // Line change 30 cycles into a burst, then re-arm on the new line.
        step(1, 1, 0, 40);
        clr_trk();
        for (int x = 0; x <= 78; x++) step(0, 1, x, 41);
        check("e_gate_before", gate_cnt, 30);
        step(0, 1, 79, 42);
        check("e_abort", burst_gate, 0);
        clr_trk();
        for (int x = 80; x <= 120; x++) step(0, 1, x, 42);
        check("e_no_regate", gate_cnt, 0);
        clr_trk();
        for (int x = 0; x <= 60; x++) step(0, 1, x, 42);
        check("e_rearm", gate_cnt, 12);
        check("e_odd", burst_odd, 0);

        // Reset in SERR, then reset mid-burst.
        step(1, 0, 0, 0);
        for (int yy = 1; yy <= 17; yy++) run_line(0, yy, 2, 1);
        for (int x = 0; x <= 100; x++) step(0, 0, x, 18);
        check("f_serr", line_state, 2);
        step(1, 0, 101, 18);
        check("f_rst_state", line_state, 0);
        check("f_rst_sync", sync_n, 1);
        check("f_rst_blank", blank, 1);
        for (int yy = 19; yy <= 24; yy++) begin
            run_line(0, yy, 2, 1);
            if (yy == 20) check("f_after_rst", line_state, 0);
        end
        for (int x = 0; x <= 55; x++) step(0, 0, x, 25);
        check("f_gate_on", burst_gate, 1);
        check("f_odd_on", burst_odd, 1);
        step(1, 0, 56, 25);
        check("f_rst_gate", burst_gate, 0);
        check("f_rst_odd", burst_odd, 0);
        clr_trk();
        for (int x = 57; x <= 80; x++) step(0, 0, x, 25);
        check("f_no_residual", gate_cnt, 0);
        for (int yy = 26; yy < 263; yy++) run_line(0, yy, 2, 1);
        for (int yy = 0; yy <= 15; yy++) begin
            run_line(0, yy, 2, 1);
            if (yy == 13) check("f_pre_vb", line_state, 0);
            if (yy == 14) check("f_eq1_again", line_state, 1);
        end

        // Randomized raster traffic.
        for (int it = 0; it < 25; it++) begin
            c   = $urandom_range(0, 3);
            vbs = (c % 2 == 1) ? 301 : 14;
            y   = ($urandom_range(0, 1) == 1) ? vbs - 2 : $urandom_range(0, 320);
            step(1, c, $urandom_range(0, 100), y);
            nl = $urandom_range(3, 12);
            for (int l = 0; l < nl; l++) begin
                r = $urandom_range(0, 7);
                if (r == 0) y = $urandom_range(0, 320);
                else begin
                    if (r == 1) c = $urandom_range(0, 3);
                    y = (y + 1) % 512;
                end
                xmax = ($urandom_range(0, 5) == 0) ? $urandom_range(250, 510)
                                                   : $urandom_range(20, 120);
                hold = $urandom_range(1, 4);
                if ($urandom_range(0, 15) == 0) step(1, c, 0, y);
                run_line(c, y, xmax, hold);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csync_sequencer.md
CSYNC_SEQUENCER -- requirements
Module: csync_sequencer

Interface
REQ-001 SHALL have parameter NTSC_BURST_LEN, default 82, giving the NTSC burst gate width in clk_dot4x cycles.
REQ-002 SHALL have parameter PAL_BURST_LEN, default 64, giving the PAL burst gate width in clk_dot4x cycles.
REQ-003 SHALL have ports:
- clk_dot4x  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- raster_x  in  10  pixel column; holds 4 clk_dot4x cycles per value.
- raster_y  in  9  raster line.
- chip  in  2  chip type; 0=6567R8, 1=6569R3, 2=6567R56A, 3=6569R1; bit0=1 means PAL.
- sync_n  out  1  composite sync; 0 = sync tip.
- blank  out  1  1 = outside native active region.
- line_state  out  3  0 ACTIVE, 1 EQ1, 2 SERR, 3 EQ2.
- burst_gate  out  1  colour burst window.
- burst_odd  out  1  raster_y[0] latched at burst start; selects PAL alternate burst phase.

Function
REQ-004 SHALL latch chip into an internal chip_l only on reset and on the first clk_dot4x cycle where raster_x==0 and raster_y==0; all timing SHALL use chip_l, so a mid-frame chip change takes effect at the next frame.
REQ-005 SHALL use per-chip constants (hsync_start, hsync_end, hvis_start, vvis_end, vblank_start, vvis_start, line_len):
- NTSC (chip_l 0, 2): 8, 45, 96, 13, 14, 23; line_len 520 (0) or 512 (2).
- PAL (chip_l 1, 3): 7, 44, 91, 300, 301, 310; line_len 504.
REQ-006 SHALL define hl = line_len/2; all compares are unsigned 10-bit.
REQ-007 SHALL detect a line start as the first cycle in which raster_y differs from its value on the previous cycle (registered prev_y).
REQ-008 FSM transitions, evaluated only on a line start:
- ACTIVE -> EQ1 when new raster_y==vblank_start.
- EQ1 -> SERR, SERR -> EQ2 and EQ2 -> ACTIVE, each after 3 line starts (2-bit line counter, cleared on every state change).
REQ-009 In EQ1 and EQ2, sync_n SHALL be 0 for raster_x in [0,19) or [hl,hl+19), and 1 otherwise.
REQ-010 In SERR, sync_n SHALL be 0 for raster_x in [0,hl-37) or [hl,line_len-37), and 1 otherwise.
REQ-011 In ACTIVE, sync_n SHALL be 0 exactly when hsync_start <= raster_x < hsync_end.
REQ-012 blank SHALL be 1 when:
- state is not ACTIVE; or
- 0 <= raster_x < hvis_start; or
- raster_y==vvis_end and raster_x>=0, or raster_y>vvis_end, provided also raster_y<vvis_start, or raster_y==vvis_start and raster_x<=hvis_start.
REQ-013 All outputs SHALL be registered, valid one clk_dot4x cycle after the raster inputs that determine them.
REQ-014 Burst start SHALL be the first cycle on which raster_x equals 49 (PAL) or 50 (NTSC) while prev raster_x differed, state==ACTIVE and blank==1; at most one start per line (armed at line start, disarmed at burst start).
REQ-015 On burst start, burst_gate SHALL rise on the next cycle and stay high for exactly NTSC_BURST_LEN or PAL_BURST_LEN cycles (8-bit down-counter); burst_odd SHALL be latched on the same edge.
REQ-016 A line start during an active burst SHALL force burst_gate to 0 on the next cycle and clear the counter; a re-arm on that same line SHALL be honoured.
REQ-017 A state change out of ACTIVE SHALL abort an active burst the same way as REQ-016.

Reset
REQ-018 While rst=1 the block SHALL drive sync_n=1, blank=1, line_state=ACTIVE, burst_gate=0, burst_odd=0, counters=0, burst disarmed, chip_l=chip, prev_y=raster_y.
REQ-019 Reset asserted mid-operation (mid-burst or in SERR) SHALL take effect on the next edge with no residual pulse after rst falls.

Verification
REQ-020 The bench SHALL cover these scenarios:
- NTSC R8, sweep a frame -> 3 lines each EQ1/SERR/EQ2 beginning at y=14; EQ sync_n low at x 0-18 and 260-278; SERR sync_n low at x 0-222 and 260-482.
- PAL, ACTIVE line -> sync_n low x 7-43; burst_gate high for exactly 64 cycles starting 1 cycle after x first equals 49; burst_odd = y[0].
- NTSC R56A -> hl=256; EQ second pulse at x 256-274.
- Change chip from 0 to 1 at y=100 -> NTSC timing to end of frame; PAL timing from y=0,x=0.
- raster_y changes at burst cycle 30 -> burst_gate=0 next cycle; no second gate on the new line unless x reaches 49/50 again.
- Assert rst during SERR mid-burst -> all outputs at REQ-018 values the next cycle; release -> ACTIVE; EQ1 only at the next y==vblank_start.
